// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-256 constants, types and key-schedule helpers
package aes_pkg;

    localparam int AES256_NK       = 8;
    localparam int AES256_NR       = 14;
    localparam int AES_SCHED_WORDS = 60;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_rk_t;

    typedef enum logic {
        ST_IDLE,
        ST_EXPAND
    } ks_state_t;

    // Round constant for schedule word i = 8*idx; only idx 1..7 occur in AES-256
    function automatic logic [7:0] aes_rcon(input logic [2:0] idx);
        logic [7:0] rc;
        case (idx)
            3'd1:    rc = 8'h01;
            3'd2:    rc = 8'h02;
            3'd3:    rc = 8'h04;
            3'd4:    rc = 8'h08;
            3'd5:    rc = 8'h10;
            3'd6:    rc = 8'h20;
            3'd7:    rc = 8'h40;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Cyclic left byte rotation of a schedule word
    function automatic aes_word_t rot_word(input aes_word_t x);
        return {x[23:0], x[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box
module aes_sbox (
    input  logic [7:0] data,
    output logic [7:0] subst
);

    // Entry 0 sits in the most significant byte, so the table reads row by row
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign subst = SBOX[data];

endmodule

// File: rtl/aes256_key_expand.sv
// rtl/aes256_key_expand.sv - iterative AES-256 key expansion with indexed round-key read port
module aes256_key_expand
    import aes_pkg::*;
#(
    parameter int NR = AES256_NR,
    parameter int NK = AES256_NK
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [255:0] i_key,
    input  logic [3:0]   i_rk_idx,
    output logic [127:0] o_rk,
    output logic         o_busy,
    output logic         o_valid,
    output logic         o_ready
);

    localparam int         WORDS = 4 * (NR + 1);
    localparam logic [5:0] FIRST = 6'(NK);
    localparam logic [5:0] LAST  = 6'(WORDS - 1);

    ks_state_t  state_q;
    ks_state_t  state_d;
    logic [5:0] cnt_q;
    aes_word_t  w_q [0:WORDS-1];

    logic       load;
    logic       step;
    logic       done;

    aes_word_t  prev_w;
    aes_word_t  back_w;
    aes_word_t  sub_in;
    aes_word_t  sub_out;
    aes_word_t  temp_w;
    aes_word_t  new_w;

    aes_rk_t    rk_tab [0:15];

    // Next-state decode: accept a start only when idle, finish on the last word
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    load    = 1'b1;
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                step = 1'b1;
                if (cnt_q == LAST) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, word counter and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= FIRST;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_ready <= 1'b0;
        end else begin
            state_q <= state_d;
            o_ready <= done;
            if (load) begin
                cnt_q   <= FIRST;
                o_busy  <= 1'b1;
                o_valid <= 1'b0;
            end else if (step) begin
                if (done) begin
                    o_busy  <= 1'b0;
                    o_valid <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 6'd1;
                end
            end
        end
    end

    // One schedule word per cycle through a single shared SubWord
    always_comb begin
        prev_w = w_q[cnt_q - 6'd1];
        back_w = w_q[cnt_q - FIRST];
        sub_in = (cnt_q[2:0] == 3'd0) ? rot_word(prev_w) : prev_w;
        case (cnt_q[2:0])
            3'd0:    temp_w = sub_out ^ {aes_rcon(cnt_q[5:3]), 24'h000000};
            3'd4:    temp_w = sub_out;
            default: temp_w = prev_w;
        endcase
        new_w = back_w ^ temp_w;
    end

    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : g_subword
            aes_sbox u_sbox (
                .data  (sub_in[8*b +: 8]),
                .subst (sub_out[8*b +: 8])
            );
        end
    endgenerate

    // Schedule register file: key words on load, one derived word per step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < WORDS; k++) begin
                w_q[k] <= '0;
            end
        end else if (load) begin
            for (int k = 0; k < NK; k++) begin
                w_q[k] <= i_key[255 - 32*k -: 32];
            end
        end else if (step) begin
            w_q[cnt_q] <= new_w;
        end
    end

    genvar r;
    generate
        for (r = 0; r < 16; r++) begin : g_rk
            if (r <= NR) begin : g_live
                assign rk_tab[r] = {w_q[4*r], w_q[4*r+1], w_q[4*r+2], w_q[4*r+3]};
            end else begin : g_zero
                assign rk_tab[r] = '0;
            end
        end
    endgenerate

    // Registered round-key read, independent of expansion state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rk <= '0;
        end else begin
            o_rk <= rk_tab[i_rk_idx];
        end
    end

endmodule

// File: tb/tb_aes256_key_expand.sv
// tb/tb_aes256_key_expand.sv - directed self-checking bench for aes256_key_expand
module tb_aes256_key_expand;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic [255:0] i_key;
    logic [3:0]   i_rk_idx;
    logic [127:0] o_rk;
    logic         o_busy;
    logic         o_valid;
    logic         o_ready;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] KEY_FIPS = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KEY_ZERO = 256'h0;

    localparam logic [127:0] FIPS_RK0  = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] FIPS_RK1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] FIPS_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] FIPS_RK3  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
    localparam logic [127:0] FIPS_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] ZERO_RK2  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK3  = 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb;
    localparam logic [127:0] ZERO_RK4  = 128'h6f6c6ccf0d0f0fac6f6c6ccf0d0f0fac;

    aes256_key_expand dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_start),
        .i_key    (i_key),
        .i_rk_idx (i_rk_idx),
        .o_rk     (o_rk),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_ready  (o_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic accept_start(input logic [255:0] key);
        i_key   = key;
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = -1;
        for (int c = 1; c <= 120; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_ready === 1'b1) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] val);
        i_rk_idx = idx;
        @(posedge clk);
        @(negedge clk);
        val = o_rk;
    endtask

    task automatic test_reset;
        logic [127:0] v;
        @(posedge clk);
        @(negedge clk);
        checks++; if (o_rk !== 128'h0) begin errors++; $display("FAIL reset_rk got %h expected 0", o_rk); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", o_busy); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", o_valid); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", o_ready); end
        rst = 1'b0;
        read_rk(4'd14, v);
        checks++; if (v !== 128'h0) begin errors++; $display("FAIL reset_rk14 got %h expected 0", v); end
    endtask

    task automatic test_fips;
        int cyc;
        logic [127:0] v;
        accept_start(KEY_FIPS);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL fips_busy got %b expected 1", o_busy); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fips_valid_low got %b expected 0", o_valid); end
        wait_ready(cyc);
        checks++; if (cyc !== 52) begin errors++; $display("FAIL fips_latency got %0d expected 52", cyc); end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL fips_valid got %b expected 1", o_valid); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL fips_busy_done got %b expected 0", o_busy); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL fips_ready_pulse got %b expected 0", o_ready); end
        read_rk(4'd1, v);
        checks++; if (v !== FIPS_RK1) begin errors++; $display("FAIL fips_rk1 got %h expected %h", v, FIPS_RK1); end
        read_rk(4'd2, v);
        checks++; if (v !== FIPS_RK2) begin errors++; $display("FAIL fips_rk2 got %h expected %h", v, FIPS_RK2); end
        read_rk(4'd3, v);
        checks++; if (v !== FIPS_RK3) begin errors++; $display("FAIL fips_rk3 got %h expected %h", v, FIPS_RK3); end
        read_rk(4'd14, v);
        checks++; if (v !== FIPS_RK14) begin errors++; $display("FAIL fips_rk14 got %h expected %h", v, FIPS_RK14); end
    endtask

    task automatic test_zero_key;
        int cyc;
        logic [127:0] v;
        accept_start(KEY_ZERO);
        wait_ready(cyc);
        checks++; if (cyc !== 52) begin errors++; $display("FAIL zero_latency got %0d expected 52", cyc); end
        read_rk(4'd0, v);
        checks++; if (v !== 128'h0) begin errors++; $display("FAIL zero_rk0 got %h expected 0", v); end
        read_rk(4'd2, v);
        checks++; if (v !== ZERO_RK2) begin errors++; $display("FAIL zero_rk2 got %h expected %h", v, ZERO_RK2); end
        read_rk(4'd3, v);
        checks++; if (v !== ZERO_RK3) begin errors++; $display("FAIL zero_rk3 got %h expected %h", v, ZERO_RK3); end
        read_rk(4'd4, v);
        checks++; if (v !== ZERO_RK4) begin errors++; $display("FAIL zero_rk4 got %h expected %h", v, ZERO_RK4); end
    endtask

    task automatic test_ignore_start;
        int pulses = 0;
        int first = -1;
        logic [127:0] v;
        accept_start(KEY_ZERO);
        for (int c = 1; c <= 80; c++) begin
            i_start = (c == 10 || c == 30);
            if (i_start) i_key = KEY_FIPS;
            @(posedge clk);
            @(negedge clk);
            if (o_ready === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        i_start = 1'b0;
        checks++; if (pulses !== 1) begin errors++; $display("FAIL ignore_pulses got %0d expected 1", pulses); end
        checks++; if (first !== 52) begin errors++; $display("FAIL ignore_latency got %0d expected 52", first); end
        read_rk(4'd2, v);
        checks++; if (v !== ZERO_RK2) begin errors++; $display("FAIL ignore_rk2 got %h expected %h", v, ZERO_RK2); end
        read_rk(4'd3, v);
        checks++; if (v !== ZERO_RK3) begin errors++; $display("FAIL ignore_rk3 got %h expected %h", v, ZERO_RK3); end
    endtask

    task automatic test_restart;
        int cyc;
        logic [127:0] v;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL restart_pre_valid got %b expected 1", o_valid); end
        accept_start(KEY_FIPS);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL restart_valid_drop got %b expected 0", o_valid); end
        wait_ready(cyc);
        checks++; if (cyc !== 52) begin errors++; $display("FAIL restart_latency got %0d expected 52", cyc); end
        read_rk(4'd1, v);
        checks++; if (v !== FIPS_RK1) begin errors++; $display("FAIL restart_rk1 got %h expected %h", v, FIPS_RK1); end
        read_rk(4'd14, v);
        checks++; if (v !== FIPS_RK14) begin errors++; $display("FAIL restart_rk14 got %h expected %h", v, FIPS_RK14); end
    endtask

    task automatic test_async_reset;
        int pulses = 0;
        int cyc;
        logic [127:0] v;
        i_rk_idx = 4'd1;
        accept_start(KEY_FIPS);
        repeat (20) @(posedge clk);
        #1;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy got %b expected 1", o_busy); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (o_rk !== 128'h0) begin errors++; $display("FAIL areset_rk got %h expected 0", o_rk); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b expected 0", o_busy); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b expected 0", o_valid); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_ready === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL areset_no_ready got %0d expected 0", pulses); end
        read_rk(4'd1, v);
        checks++; if (v !== 128'h0) begin errors++; $display("FAIL areset_words got %h expected 0", v); end
        accept_start(KEY_FIPS);
        wait_ready(cyc);
        checks++; if (cyc !== 52) begin errors++; $display("FAIL areset_latency got %0d expected 52", cyc); end
        read_rk(4'd14, v);
        checks++; if (v !== FIPS_RK14) begin errors++; $display("FAIL areset_rk14 got %h expected %h", v, FIPS_RK14); end
    endtask

    task automatic test_read_sweep;
        logic [127:0] exp_rk;
        logic [127:0] key_hi;
        bit known;
        key_hi = KEY_FIPS[255:128];
        checks++; if (key_hi !== FIPS_RK0) begin errors++; $display("FAIL sweep_key_hi got %h expected %h", key_hi, FIPS_RK0); end
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) i_rk_idx = 4'(k);
            #1;
            if (k > 0) begin
                known = 1'b1;
                case (k - 1)
                    0:       exp_rk = key_hi;
                    1:       exp_rk = FIPS_RK1;
                    2:       exp_rk = FIPS_RK2;
                    3:       exp_rk = FIPS_RK3;
                    14:      exp_rk = FIPS_RK14;
                    15:      exp_rk = 128'h0;
                    default: begin exp_rk = 128'h0; known = 1'b0; end
                endcase
                if (known) begin
                    checks++;
                    if (o_rk !== exp_rk) begin
                        errors++;
                        $display("FAIL sweep_idx%0d got %h expected %h", k - 1, o_rk, exp_rk);
                    end
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        int rdy_bad = 0;
        int val_bad = 0;
        int busy_bad = 0;
        int cyc;
        logic exp_done;
        logic [127:0] v;
        i_key   = KEY_FIPS;
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= 170; c++) begin
            @(posedge clk);
            @(negedge clk);
            exp_done = (c >= 52) && (((c - 52) % 53) == 0);
            if (o_ready === 1'b1) pulses++;
            if (o_ready !== exp_done) rdy_bad++;
            if (o_valid !== exp_done) val_bad++;
            if (o_busy !== !exp_done) busy_bad++;
        end
        i_start = 1'b0;
        checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses got %0d expected 3", pulses); end
        checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL b2b_ready_timing got %0d bad cycles expected 0", rdy_bad); end
        checks++; if (val_bad !== 0) begin errors++; $display("FAIL b2b_valid_timing got %0d bad cycles expected 0", val_bad); end
        checks++; if (busy_bad !== 0) begin errors++; $display("FAIL b2b_busy_timing got %0d bad cycles expected 0", busy_bad); end
        wait_ready(cyc);
        checks++; if (cyc !== 41) begin errors++; $display("FAIL b2b_tail got %0d expected 41", cyc); end
        read_rk(4'd14, v);
        checks++; if (v !== FIPS_RK14) begin errors++; $display("FAIL b2b_rk14 got %h expected %h", v, FIPS_RK14); end
    endtask

    initial begin
        rst      = 1'b1;
        i_start  = 1'b0;
        i_key    = '0;
        i_rk_idx = '0;
        test_reset;
        test_fips;
        test_zero_key;
        test_ignore_start;
        test_restart;
        test_async_reset;
        test_read_sweep;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
